error_scoreboard: RTL
=====================

ERROR_SCOREBOARD -- requirements
Module: error_scoreboard

Interface
REQ-001 The block SHALL have parameter DATAWIDTH, default 16, bit width of one channel sample.
REQ-002 The block SHALL have parameter NUM_CH, default 4, channels compared in parallel (1..16).
REQ-003 The block SHALL have parameter REF_DELAY, default 0, cycles of delay applied to ref/valid before compare (0..15).
REQ-004 The block SHALL have parameter CNT_WIDTH, default 16, width of the saturating counters.
REQ-005 The block SHALL have parameter HALT_ON_ERR, default 0; when 1, counters freeze after the first error.
REQ-006 The block SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-007 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-008 The block SHALL have port meas, input, NUM_CH*DATAWIDTH, DUT outputs; channel k is bits [k*DATAWIDTH +: DATAWIDTH].
REQ-009 The block SHALL have port ref, input, NUM_CH*DATAWIDTH, reference-model outputs with the same packing.
REQ-010 The block SHALL have port valid, input, 1, qualifies ref for the current cycle.
REQ-011 The block SHALL have port tol, input, DATAWIDTH, allowed unsigned absolute difference (0 = exact match).
REQ-012 The block SHALL have port clear, input, 1, synchronous clear of status and counters.
REQ-013 The block SHALL have port err, output, 1, one-cycle pulse for a failing compare.
REQ-014 The block SHALL have port err_ch, output, NUM_CH, per-channel fail mask of that compare.
REQ-015 The block SHALL have port err_sticky, output, 1, high from the first failure until clear or reset.
REQ-016 The block SHALL have port err_count, output, CNT_WIDTH, count of failing compares.
REQ-017 The block SHALL have port sample_count, output, CNT_WIDTH, count of compares performed.
REQ-018 The block SHALL have port first_err_idx, output, CNT_WIDTH, sample_count value at the first failure.
REQ-019 The block SHALL have port first_err_ch, output, NUM_CH, err_ch mask of the first failure.

Function
REQ-020 The block SHALL delay ref and valid by REF_DELAY cycles through a shift register; with REF_DELAY=0, compare uses the same-cycle inputs.
REQ-021 The block SHALL perform a compare in every cycle where delayed valid is 1; meas is sampled in that same cycle.
REQ-022 The block SHALL flag channel k when |meas_k - ref_k| > tol, computed unsigned in DATAWIDTH+1 bits with no wrap.
REQ-023 The block SHALL register err and err_ch one cycle after the compare cycle; err = OR of err_ch; both are 0 in non-compare cycles.
REQ-024 The block SHALL increment sample_count per compare and err_count per failing compare, each saturating at all-ones.
REQ-025 The block SHALL implement FSM RUN -> FAILED on the first failing compare, and FAILED -> RUN on clear.
REQ-026 The block SHALL capture first_err_idx (pre-increment sample_count) and first_err_ch only on the RUN -> FAILED transition.
REQ-027 The block SHALL drive err_sticky high exactly while the FSM is in FAILED.
REQ-028 The block SHALL freeze both counters in FAILED when HALT_ON_ERR=1; err and err_ch keep reporting.
REQ-029 The block SHALL give clear priority over a same-cycle compare: that compare is discarded, counters go to 0, FSM goes to RUN.
REQ-030 The block SHALL leave the delay line unchanged on clear; in-flight samples compare normally afterwards.

Reset
REQ-031 The block SHALL, on rst, asynchronously set all outputs to 0, the FSM to RUN, and every delay-line valid bit to 0.
REQ-032 The block SHALL ignore in-flight samples after rst deasserts; the first compare requires a valid sampled after reset.

Structure
REQ-033 The block SHALL take FSM state encodings (RUN=0, FAILED=1) from the shared package scoreboard_pkg.
REQ-034 The block SHALL implement the ref/valid delay as one sub-module, delay_line, parameterised by width and depth; depth 0 is a wire.

Verification
REQ-035 The bench SHALL check NUM_CH=4, REF_DELAY=0, tol=0, meas=ref for 10 valids -> err never 1, sample_count=10, err_sticky=0.
REQ-036 The bench SHALL check that ch2 meas=ref+3 on sample 5 with tol=2 -> err=1 one cycle later, err_ch=4'b0100, first_err_idx=4, err_count=1.
REQ-037 The bench SHALL check REF_DELAY=3 with meas lagging ref by 3 cycles -> no errors; with a lag of 2 cycles -> errors flagged.
REQ-038 The bench SHALL check CNT_WIDTH=4 with 20 failing compares -> err_count=15, and sample_count=15.
REQ-039 The bench SHALL check clear together with a failing compare -> err_count=0, err_sticky=0, FSM=RUN, and no err pulse.
REQ-040 The bench SHALL check rst asserted mid-stream while REF_DELAY=3 -> outputs 0 immediately, and no compare until a new valid propagates.

Source files
------------

// File: rtl/scoreboard_pkg.sv
// Shared definitions for the error scoreboard: FSM state encoding.
package scoreboard_pkg;

   typedef enum logic [0:0] {
      ST_RUN    = 1'b0,
      ST_FAILED = 1'b1
   } sb_state_e;

endpackage

// File: rtl/error_scoreboard_delay_line.sv
// Fixed-latency pipeline for the reference bus and its valid bit.
// DEPTH=0 degenerates to a plain wire.
module delay_line #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din_i,
   output logic [WIDTH-1:0] dout_o
);

   generate
      if (DEPTH == 0) begin : g_wire
         logic unused_clk_rst_s;
         assign unused_clk_rst_s = clk ^ rst;
         assign dout_o = din_i;
      end else begin : g_shift
         logic [WIDTH-1:0] stage_q [DEPTH];

         // Shift stages; reset clears the valid bit carried in each stage
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               for (int i = 0; i < DEPTH; i++) begin
                  stage_q[i] <= '0;
               end
            end else begin
               stage_q[0] <= din_i;
               for (int i = 1; i < DEPTH; i++) begin
                  stage_q[i] <= stage_q[i-1];
               end
            end
         end

         assign dout_o = stage_q[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/error_scoreboard.sv
// Multi-channel measured-vs-reference comparator with tolerance, saturating
// counters and first-failure capture.
module error_scoreboard
   import scoreboard_pkg::*;
#(
   parameter int DATAWIDTH   = 16,
   parameter int NUM_CH      = 4,
   parameter int REF_DELAY   = 0,
   parameter int CNT_WIDTH   = 16,
   parameter bit HALT_ON_ERR = 1'b0
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_CH*DATAWIDTH-1:0] meas,
   input  logic [NUM_CH*DATAWIDTH-1:0] ref_data,
   input  logic                        valid,
   input  logic [DATAWIDTH-1:0]        tol,
   input  logic                        clear,
   output logic                        err,
   output logic [NUM_CH-1:0]           err_ch,
   output logic                        err_sticky,
   output logic [CNT_WIDTH-1:0]        err_count,
   output logic [CNT_WIDTH-1:0]        sample_count,
   output logic [CNT_WIDTH-1:0]        first_err_idx,
   output logic [NUM_CH-1:0]           first_err_ch
);

   localparam int BUS_W = NUM_CH * DATAWIDTH;

   // Difference taken one bit wider than the data so it never wraps.
   function automatic logic out_of_tol(input logic [DATAWIDTH-1:0] m,
                                       input logic [DATAWIDTH-1:0] r,
                                       input logic [DATAWIDTH-1:0] t);
      logic [DATAWIDTH:0] mx;
      logic [DATAWIDTH:0] rx;
      logic [DATAWIDTH:0] diff;
      mx   = {1'b0, m};
      rx   = {1'b0, r};
      diff = (mx >= rx) ? (mx - rx) : (rx - mx);
      return (diff > {1'b0, t});
   endfunction

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
      return (&c) ? c : (c + CNT_WIDTH'(1));
   endfunction

   logic [BUS_W:0]    dly_in_s;
   logic [BUS_W:0]    dly_out_s;
   logic [BUS_W-1:0]  ref_dly_s;
   logic              valid_dly_s;
   logic [NUM_CH-1:0] fail_s;
   logic              any_fail_s;
   logic              halted_s;

   sb_state_e         state_q,     state_d;
   logic              err_q,       err_d;
   logic [NUM_CH-1:0] err_ch_q,    err_ch_d;
   logic [CNT_WIDTH-1:0] err_cnt_q,   err_cnt_d;
   logic [CNT_WIDTH-1:0] smp_cnt_q,   smp_cnt_d;
   logic [CNT_WIDTH-1:0] first_idx_q, first_idx_d;
   logic [NUM_CH-1:0] first_ch_q,  first_ch_d;

   assign dly_in_s = {valid, ref_data};
   assign {valid_dly_s, ref_dly_s} = dly_out_s;

   delay_line #(
      .WIDTH (BUS_W + 1),
      .DEPTH (REF_DELAY)
   ) u_ref_dly (
      .clk    (clk),
      .rst    (rst),
      .din_i  (dly_in_s),
      .dout_o (dly_out_s)
   );

   // Per-channel tolerance check against the delayed reference
   always_comb begin
      fail_s = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         fail_s[k] = valid_dly_s &
                     out_of_tol(meas[k*DATAWIDTH +: DATAWIDTH],
                                ref_dly_s[k*DATAWIDTH +: DATAWIDTH], tol);
      end
   end

   assign any_fail_s = |fail_s;
   assign halted_s   = HALT_ON_ERR && (state_q == ST_FAILED);

   // Next state for FSM, counters and capture registers; clear wins over a compare
   always_comb begin
      state_d     = state_q;
      err_cnt_d   = err_cnt_q;
      smp_cnt_d   = smp_cnt_q;
      first_idx_d = first_idx_q;
      first_ch_d  = first_ch_q;
      err_ch_d    = '0;

      if (clear) begin
         state_d     = ST_RUN;
         err_cnt_d   = '0;
         smp_cnt_d   = '0;
         first_idx_d = '0;
         first_ch_d  = '0;
      end else if (valid_dly_s) begin
         err_ch_d = fail_s;

         if (!halted_s) begin
            smp_cnt_d = sat_inc(smp_cnt_q);
            if (any_fail_s) begin
               err_cnt_d = sat_inc(err_cnt_q);
            end else begin
               err_cnt_d = err_cnt_q;
            end
         end else begin
            smp_cnt_d = smp_cnt_q;
            err_cnt_d = err_cnt_q;
         end

         case (state_q)
            ST_RUN: begin
               if (any_fail_s) begin
                  state_d     = ST_FAILED;
                  first_idx_d = smp_cnt_q;
                  first_ch_d  = fail_s;
               end else begin
                  state_d = ST_RUN;
               end
            end
            ST_FAILED: state_d = ST_FAILED;
            default:   state_d = ST_RUN;
         endcase
      end else begin
         err_ch_d = '0;
      end
   end

   assign err_d = |err_ch_d;

   // State and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_RUN;
         err_q       <= 1'b0;
         err_ch_q    <= '0;
         err_cnt_q   <= '0;
         smp_cnt_q   <= '0;
         first_idx_q <= '0;
         first_ch_q  <= '0;
      end else begin
         state_q     <= state_d;
         err_q       <= err_d;
         err_ch_q    <= err_ch_d;
         err_cnt_q   <= err_cnt_d;
         smp_cnt_q   <= smp_cnt_d;
         first_idx_q <= first_idx_d;
         first_ch_q  <= first_ch_d;
      end
   end

   assign err           = err_q;
   assign err_ch        = err_ch_q;
   assign err_sticky    = (state_q == ST_FAILED);
   assign err_count     = err_cnt_q;
   assign sample_count  = smp_cnt_q;
   assign first_err_idx = first_idx_q;
   assign first_err_ch  = first_ch_q;

endmodule
